// File: rtl/snake_control.sv
// Control FSM for the snake datapath: init, move timing, erase/shift/redraw passes,
// food plot, growth and death, plus push-button steering and plot colour.
module snake_control #(
    parameter int INIT_LEN = 4,
    parameter int MAX_LEN  = 2047,
    parameter int MOVE_DIV = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        isDead,
    input  logic        inc_length,
    output logic        ld_head,
    output logic        ld_q_def,
    output logic        inc_address,
    output logic        rst_address,
    output logic        update_head,
    output logic        ld_head_into_prev,
    output logic        ld_q_into_curr,
    output logic        ld_prev_into_q,
    output logic        ld_curr_into_prev,
    output logic        draw_q,
    output logic        draw_curr,
    output logic        food_en,
    output logic        check_inc,
    output logic        lock,
    output logic [1:0]  cnt_status,
    output logic [2:0]  dir,
    output logic [2:0]  colour,
    output logic [10:0] length,
    output logic        dead
);

    localparam int CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    localparam logic [2:0] DIR_UP    = 3'b100;
    localparam logic [2:0] DIR_DOWN  = 3'b110;
    localparam logic [2:0] DIR_LEFT  = 3'b000;
    localparam logic [2:0] DIR_RIGHT = 3'b001;

    typedef enum logic [4:0] {
        S_IDLE, S_INIT, S_FILL,
        S_ER_RST, S_ER_RD, S_ER_PIX,
        S_SHIFT, S_SH_RST, S_SH_RD, S_SH_CUR, S_SH_WR, S_SH_NX,
        S_DR_RST, S_DR_RD, S_DR_PIX,
        S_FOOD, S_CHECK, S_GROW, S_WAIT, S_DEAD
    } state_t;

    state_t        state, next_state;
    logic [10:0]   seg;
    logic [1:0]    pix;
    logic [CW-1:0] move_cnt;
    logic [2:0]    pend, req, next_pend;
    logic          pressed;
    logic          first_pass;
    logic          seg_last, pix_last, fill_last, move_done;

    assign seg_last  = (seg == length - 11'd1);
    assign pix_last  = (pix == 2'd3);
    assign fill_last = (seg == 11'(INIT_LEN - 1));
    assign move_done = (move_cnt == CW'(MOVE_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    // Segment index, pixel sub-index, move timer, length and the first-pass flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg        <= '0;
            pix        <= '0;
            move_cnt   <= '0;
            length     <= '0;
            first_pass <= 1'b0;
        end else begin
            case (state)
                S_INIT, S_ER_RST, S_SH_RST, S_DR_RST: seg <= '0;
                S_FILL, S_SH_NX:                     seg <= seg + 11'd1;
                S_ER_PIX, S_DR_PIX:                  if (pix_last) seg <= seg + 11'd1;
                default: ;
            endcase
            pix      <= (state inside {S_ER_PIX, S_DR_PIX, S_FOOD}) ? pix + 2'd1 : 2'd0;
            move_cnt <= (state == S_WAIT && !move_done) ? move_cnt + CW'(1) : '0;
            if (state == S_FILL && fill_last) length <= 11'(INIT_LEN);
            else if (state == S_GROW)         length <= length + 11'd1;
            if (state == S_INIT)      first_pass <= 1'b1;
            else if (state == S_WAIT) first_pass <= 1'b0;
        end
    end

    // Highest-priority pressed button; a reversal shares the axis bit but differs
    always_comb begin
        pressed = 1'b1;
        if (btn_up)         req = DIR_UP;
        else if (btn_down)  req = DIR_DOWN;
        else if (btn_left)  req = DIR_LEFT;
        else if (btn_right) req = DIR_RIGHT;
        else begin
            req     = pend;
            pressed = 1'b0;
        end
        next_pend = pend;
        if (pressed && !(req[2] == dir[2] && req != dir)) next_pend = req;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= DIR_RIGHT;
            dir  <= DIR_RIGHT;
        end else begin
            pend <= next_pend;
            if (state == S_SHIFT) dir <= pend;
        end
    end

    always_comb begin
        next_state        = state;
        ld_head           = 1'b0;
        ld_q_def          = 1'b0;
        inc_address       = 1'b0;
        rst_address       = 1'b0;
        update_head       = 1'b0;
        ld_head_into_prev = 1'b0;
        ld_q_into_curr    = 1'b0;
        ld_prev_into_q    = 1'b0;
        ld_curr_into_prev = 1'b0;
        draw_q            = 1'b0;
        draw_curr         = 1'b0;
        food_en           = 1'b0;
        check_inc         = 1'b0;
        lock              = 1'b0;
        colour            = 3'b000;
        dead              = 1'b0;
        case (state)
            S_IDLE: if (go) next_state = S_INIT;
            S_INIT: begin
                ld_head     = 1'b1;
                rst_address = 1'b1;
                next_state  = S_FILL;
            end
            S_FILL: begin
                ld_q_def    = 1'b1;
                inc_address = 1'b1;
                if (fill_last) next_state = S_DR_RST;
            end
            S_ER_RST: begin
                rst_address = 1'b1;
                next_state  = S_ER_RD;
            end
            S_ER_RD: next_state = S_ER_PIX;
            S_ER_PIX: begin
                draw_q = 1'b1;
                if (pix_last) begin
                    inc_address = 1'b1;
                    next_state  = seg_last ? S_SHIFT : S_ER_RD;
                end
            end
            S_SHIFT: begin
                ld_head_into_prev = 1'b1;
                update_head       = 1'b1;
                next_state        = S_SH_RST;
            end
            S_SH_RST: begin
                rst_address = 1'b1;
                next_state  = S_SH_RD;
            end
            S_SH_RD:  next_state = S_SH_CUR;
            S_SH_CUR: begin
                ld_q_into_curr = 1'b1;
                next_state     = S_SH_WR;
            end
            S_SH_WR: begin
                ld_prev_into_q = 1'b1;
                next_state     = S_SH_NX;
            end
            S_SH_NX: begin
                ld_curr_into_prev = 1'b1;
                inc_address       = 1'b1;
                next_state        = seg_last ? S_DR_RST : S_SH_RD;
            end
            S_DR_RST: begin
                rst_address = 1'b1;
                colour      = 3'b010;
                next_state  = S_DR_RD;
            end
            S_DR_RD: begin
                colour     = 3'b010;
                next_state = S_DR_PIX;
            end
            S_DR_PIX: begin
                draw_q = 1'b1;
                colour = 3'b010;
                if (pix_last) begin
                    inc_address = 1'b1;
                    if (!seg_last)       next_state = S_DR_RD;
                    else if (isDead)     next_state = S_DEAD;
                    else if (first_pass) next_state = S_WAIT;
                    else                 next_state = S_FOOD;
                end
            end
            S_FOOD: begin
                food_en = 1'b1;
                colour  = 3'b100;
                if (pix_last) next_state = S_CHECK;
            end
            S_CHECK: begin
                check_inc = 1'b1;
                if (isDead)                                         next_state = S_DEAD;
                else if (inc_length && length < 11'(MAX_LEN))       next_state = S_GROW;
                else                                                next_state = S_WAIT;
            end
            // Address sits at length after the draw pass, so this appends the old tail
            S_GROW: begin
                ld_prev_into_q = 1'b1;
                next_state     = S_WAIT;
            end
            S_WAIT: begin
                if (move_done) begin
                    lock       = 1'b1;
                    next_state = S_ER_RST;
                end
            end
            S_DEAD:  dead = 1'b1;
            default: next_state = S_IDLE;
        endcase
    end

    assign cnt_status = pix;

endmodule
